// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Sequences a wide unsigned add through an external 4-bit adder whose carry-in
// is tied low. Operands are processed one nibble at a time, least significant
// first. A carry into a nibble is applied with a second adder pass that adds
// 0001 to the held partial sum.
// Optional feature macro: SERIAL_ADD_OVF_EN (signed overflow flag on ovf).
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   carry_out,
  output logic                   ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_INC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          c;
  logic [3:0]    tmp;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;

  logic accept;
  logic last;
  logic nib_write;
  logic c_fin;
  logic entering_done;

  assign accept        = start && ((state == S_IDLE) || (state == S_DONE));
  assign last          = (idx == IW'(NIBBLES - 1));
  // A nibble result is final either on a carry-free ADD pass or on an INC pass
  assign nib_write     = ((state == S_ADD) && !c) || (state == S_INC);
  assign c_fin         = (state == S_INC) ? (c | add_cout) : add_cout;
  assign entering_done = nib_write && last;

  assign busy = (state == S_ADD) || (state == S_INC);
  assign done = (state == S_DONE);

  // Adder operand selection from the current state
  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state)
      S_ADD: begin
        add_a = a_q[{idx, 2'b00} +: 4];
        add_b = b_q[{idx, 2'b00} +: 4];
      end
      S_INC: begin
        add_a = tmp;
        add_b = 4'b0001;
      end
      default: ;
    endcase
  end

  // Sequencer state, nibble index, running carry and result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      c         <= 1'b0;
      tmp       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q       <= op_a;
            b_q       <= op_b;
            idx       <= '0;
            c         <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            state     <= S_ADD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ADD: begin
          if (c) begin
            tmp   <= add_sum;
            c     <= add_cout;
            state <= S_INC;
          end else begin
            sum[{idx, 2'b00} +: 4] <= add_sum;
            c <= add_cout;
            if (last) begin
              carry_out <= add_cout;
              state     <= S_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_INC: begin
          sum[{idx, 2'b00} +: 4] <= add_sum;
          c <= c_fin;
          if (last) begin
            carry_out <= c_fin;
            state     <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_ADD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // Signed overflow: the MSB of the final sum is the nibble being written now
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (accept) begin
      ovf <= 1'b0;
    end else if (entering_done) begin
      ovf <= (a_q[W-1] == b_q[W-1]) && (add_sum[3] != a_q[W-1]);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl (NIBBLES=4) with a behavioural 4-bit
// adder and a reference model based on plain wide arithmetic.
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic [3:0]  add_sum;
  logic        add_cout;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        carry_out;
  logic        ovf;

  int n_chk  = 0;
  int n_fail = 0;
  int bcnt;
  logic [3:0] trace [0:63];

  always #5 clk = ~clk;

  // 4-bit adder with carry-in tied low
  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b);

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .ovf(ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: request an operation at the next rising edge
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
  endtask

  // Follows one launched operation. ign_at/rst_at: busy cycle (1-based) on which
  // to pulse a stray start or assert reset (0 = never). chain: launch na+nb in
  // the done cycle.
  task automatic expect_op(input logic [15:0] a, input logic [15:0] b,
                           input int ign_at, input int rst_at,
                           input logic chain, input logic [15:0] na, input logic [15:0] nb);
    longint unsigned aa, bb, m, full;
    int   k, cyc, dcnt;
    logic ov, seen;
    aa   = 64'(a);
    bb   = 64'(b);
    full = aa + bb;
    k = 0;
    for (int i = 1; i < 4; i++) begin
      m = (64'd1 << (4 * i)) - 1;
      if ((((aa & m) + (bb & m)) >> (4 * i)) != 0) k++;
    end
`ifdef SERIAL_ADD_OVF_EN
    ov = (a[15] == b[15]) && (full[15] != a[15]);
`else
    ov = 1'b0;
`endif
    bcnt = 0;
    seen = 1'b0;
    cyc  = 1;
    @(negedge clk);
    start = 1'b0;
    while (!seen && cyc <= 40) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) begin
          trace[bcnt] = add_b;
          bcnt++;
        end
        if (cyc == rst_at) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check("rst_busy", 32'(busy), 0);
          check("rst_done", 32'(done), 0);
          check("rst_sum", 32'(sum), 0);
          check("rst_cout", 32'(carry_out), 0);
          dcnt = 0;
          repeat (8) begin
            @(negedge clk);
            if (done) dcnt++;
          end
          check("rst_no_done", 32'(dcnt), 0);
          return;
        end
        start = (cyc == ign_at);
        if (cyc == ign_at) begin
          op_a = 16'($urandom);
          op_b = 16'($urandom);
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 1);
    check("sum", 32'(sum), 32'(full[15:0]));
    check("carry_out", 32'(carry_out), 32'(full[16]));
    check("ovf", 32'(ovf), 32'(ov));
    check("busy_cycles", 32'(bcnt), 32'(4 + k));
    check("idle_add_a", 32'(add_a), 0);
    check("idle_add_b", 32'(add_b), 0);
    if (chain) begin
      launch(na, nb);
    end else begin
      @(negedge clk);
      check("done_single", 32'(done), 0);
      check("busy_after", 32'(busy), 0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_sum", 32'(sum), 0);
    check("reset_cout", 32'(carry_out), 0);
    check("reset_ovf", 32'(ovf), 0);
    check("reset_add_a", 32'(add_a), 0);
    check("reset_add_b", 32'(add_b), 0);
    rst = 1'b0;
    @(negedge clk);

    launch(16'h0001, 16'h0002);
    expect_op(16'h0001, 16'h0002, 0, 0, 1'b0, '0, '0);

    launch(16'h00FF, 16'h0001);
    expect_op(16'h00FF, 16'h0001, 0, 0, 1'b0, '0, '0);
    check("inc1_add_b", 32'(trace[2]), 1);
    check("inc2_add_b", 32'(trace[4]), 1);

    launch(16'hFFFF, 16'h0001);
    expect_op(16'hFFFF, 16'h0001, 0, 0, 1'b0, '0, '0);

    launch(16'h7FFF, 16'h0001);
    expect_op(16'h7FFF, 16'h0001, 0, 0, 1'b0, '0, '0);

    launch(16'h1234, 16'h1111);
    expect_op(16'h1234, 16'h1111, 2, 0, 1'b1, 16'hFFFF, 16'hFFFF);
    expect_op(16'hFFFF, 16'hFFFF, 0, 0, 1'b0, '0, '0);

    launch(16'h00FF, 16'h0001);
    expect_op(16'h00FF, 16'h0001, 0, 3, 1'b0, '0, '0);

    for (int n = 0; n < 24; n++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 4 == 0) rb = ~ra + 16'($urandom_range(0, 2));
      launch(ra, rb);
      expect_op(ra, rb, 0, 0, 1'b0, '0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Multi-precision add sequencer that sits directly upstream and downstream of the team's 4-bit ripple adder. It slices two `4*NIBBLES`-bit operands into nibbles, least significant first. It drives each nibble pair into the adder's operand inputs, captures the adder's sum and carry-out, and assembles the wide result. The adder's carry-in is hard-wired to 0, so inter-nibble carry is injected with a second adder pass that adds `0001` to the partial sum.

## Interface

Parameters:
- `NIBBLES`, default 4: operand width in nibbles; legal range 2..16.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new addition; sampled on the rising edge.
- `op_a`  in  `4*NIBBLES`  operand A; captured internally on an accepted `start`.
- `op_b`  in  `4*NIBBLES`  operand B; captured internally on an accepted `start`.
- `add_a`  out  4  adder operand 1 (to adder `nr1`); combinational from state.
- `add_b`  out  4  adder operand 2 (to adder `nr2`); combinational from state.
- `add_sum`  in  4  adder result (from adder `out`).
- `add_cout`  in  1  adder carry-out (from adder `cout`).
- `busy`  out  1  high during ADD and INC.
- `done`  out  1  one-cycle pulse; `sum`/`carry_out`/`ovf` valid.
- `sum`  out  `4*NIBBLES`  result; holds until the next accepted `start`.
- `carry_out`  out  1  unsigned carry out of the MSB nibble.
- `ovf`  out  1  signed overflow flag (see Configuration).

## Operation

States:
- IDLE
- ADD: adder computes nibble `i` of A plus nibble `i` of B.
- INC: adder computes the held partial sum plus `0001`.
- DONE

Internal registers:
- `idx`: nibble index, `ceil(log2(NIBBLES))` bits.
- `c`: running carry.
- `tmp`: 4-bit held partial sum.
- Captured copies of both operands.

Behaviour by state:
- IDLE / DONE: `start=1` captures `op_a`/`op_b`, sets `idx=0`, `c=0`, clears `sum`, `carry_out` and `ovf`, and moves to ADD. Otherwise IDLE stays in IDLE, and DONE returns to IDLE.
- ADD: `add_a` = A nibble `idx`, `add_b` = B nibble `idx`. At the edge:
  - If `c=0`: write `add_sum` into `sum` nibble `idx` and set `c=add_cout`. Then go to ADD with `idx+1`, or to DONE if `idx=NIBBLES-1`.
  - If `c=1`: set `tmp=add_sum`, set `c=add_cout`, and go to INC.
- INC: `add_a=tmp`, `add_b=4'b0001`. At the edge: write `add_sum` into `sum` nibble `idx`, set `c=c|add_cout`, then advance exactly as ADD does with `c=0`.
- Entering DONE: `carry_out=c`.
- `add_a`/`add_b` are 0 in IDLE and DONE.
- The pair (ADD `add_cout`, INC `add_cout`) can never be (1,1). No assertion is required.
- Arithmetic is unsigned, modulo `2^(4*NIBBLES)`. `carry_out` is bit `4*NIBBLES` of the true sum.
- `start` during ADD or INC is ignored. Operands in flight are unaffected.

## Timing

- Reset values: state IDLE; `busy=0`, `done=0`, `sum=0`, `carry_out=0`, `ovf=0`, `add_a=0`, `add_b=0`; internal registers 0.
- `rst` has priority over everything. Asserted mid-operation, it aborts the operation and discards the partial `sum` (cleared to 0) on that edge.
- The adder path is purely combinational. `add_sum`/`add_cout` must settle within the same cycle that `add_a`/`add_b` are driven, and are sampled at that cycle's closing edge.
- Latency: with the accepting edge at T0, `busy=1` for exactly `NIBBLES+K` cycles, where K is the number of INC passes (nibbles `i>=1` entered with carry 1). `done=1` in the following cycle only.
- Back-to-back: `start=1` in the DONE cycle begins the next operation with no IDLE bubble. `done` still pulses only once.
- Nibble 0 never takes an INC pass.

## Configuration

- `SERIAL_ADD_OVF_EN` defined:
  - On entry to DONE, `ovf` = (A[MSB]==B[MSB]) && (sum[MSB]!=A[MSB]), using the captured operands and the final sum.
  - `ovf` holds until the next accepted `start`.
- `SERIAL_ADD_OVF_EN` undefined: `ovf` is tied to 0 and the comparison logic is absent. The port remains.

## Test plan

All scenarios use `NIBBLES=4` with the real 4-bit adder instantiated in the bench.
- `0x0001 + 0x0002` -> `sum=0x0003`, `carry_out=0`, `busy` for 4 cycles, `done` in cycle 5, `ovf=0`.
- `0x00FF + 0x0001` -> `sum=0x0100`, `carry_out=0`, K=2, `busy` for 6 cycles; `add_b=0001` observed in both INC cycles.
- `0xFFFF + 0x0001` -> `sum=0x0000`, `carry_out=1`, K=3, `busy` for 7 cycles, `ovf=0`.
- `0x7FFF + 0x0001` -> `sum=0x8000`, `carry_out=0`; `ovf=1` with `SERIAL_ADD_OVF_EN`, `ovf=0` without.
- Start `0x1234 + 0x1111`; pulse `start` with different operands on busy cycle 2 -> ignored, `sum=0x2345`. Then `start` in the DONE cycle with `0xFFFF + 0xFFFF` -> `sum=0xFFFE`, `carry_out=1`, single `done` per operation.
- Start `0x00FF + 0x0001`; assert `rst` on busy cycle 3 -> next cycle IDLE with `busy=0`, `done=0`, `sum=0`, and no `done` pulse ever appears for the aborted operation.
